// File: rtl/stg_pkg.sv
// Shared types and default constants for the bullet pool scheduler.
// Holds the FSM encoding, the pool defaults and the slot-index type.
package stg_pkg;

    localparam int DEF_NUM_SLOTS  = 16;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_CLEAR_HOLD = 1000;
    localparam int DEF_SLOT_W     = $clog2(DEF_NUM_SLOTS);

    typedef logic [DEF_SLOT_W-1:0] slot_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps.
// Ports: req_i, ptr_i, en_i in; one-hot gnt_o, winner idx_o, valid_o out.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // candidate = (ptr + i) mod NUM_REQ, NUM_REQ need not be a power of two
            sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ))
                sum = sum - (IDX_W+1)'(NUM_REQ);
            cand = sum[IDX_W-1:0];
            if (en_i && !valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/bullet_pool_scheduler.sv
// Round-robin allocator of a shared bullet slot pool with occupancy tracking.
// Ports: clk, hard_reset_n, game_en, game_reset, clear_all, req, release_*
// in; grant, grant_valid, grant_slot, slot_busy, busy_count, pool_full,
// bad_release out (all registered).
module bullet_pool_scheduler
    import stg_pkg::*;
#(
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int SLOT_W     = $clog2(NUM_SLOTS),
    parameter int CLEAR_HOLD = DEF_CLEAR_HOLD
) (
    input  logic                 clk,
    input  logic                 hard_reset_n,
    input  logic                 game_en,
    input  logic                 game_reset,
    input  logic                 clear_all,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 grant_valid,
    output logic [SLOT_W-1:0]    grant_slot,
    input  logic                 release_valid,
    input  logic [SLOT_W-1:0]    release_slot,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [SLOT_W:0]      busy_count,
    output logic                 pool_full,
    output logic                 bad_release
);

    localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = SLOT_W + 1;
    localparam int HOLD_W = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CLEAR_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUM_SLOTS);
    localparam logic [REQ_W-1:0]  PTR_LAST  = REQ_W'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [REQ_W-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 gvalid_q, gvalid_d;
    logic [SLOT_W-1:0]    gslot_q, gslot_d;
    logic                 full_q, full_d;
    logic                 badrel_q, badrel_d;

    logic                 free_any;
    logic [SLOT_W-1:0]    free_idx;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [REQ_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 rel_ok;

    // Lowest-index free slot, chosen from occupancy before this edge
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_any = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    // game_reset and clear_all both suppress any grant this cycle
    assign arb_en = (state_q == ST_RUN) && game_en && free_any &&
                    !game_reset && !clear_all;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        grant_d  = '0;
        gvalid_d = 1'b0;
        gslot_d  = '0;
        badrel_d = 1'b0;
        rel_ok   = 1'b0;
        if (game_reset) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            hold_d  = '0;
            busy_d  = '0;
            cnt_d   = '0;
        end else if (clear_all) begin
            state_d = ST_CLEAR;
            hold_d  = HOLD_LOAD;
            busy_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE:  if (game_en) state_d = ST_RUN;
                ST_RUN:   if (!game_en) state_d = ST_IDLE;
                ST_CLEAR: begin
                    if (hold_q == '0)
                        state_d = game_en ? ST_RUN : ST_IDLE;
                    else
                        hold_d = hold_q - HOLD_W'(1);
                end
                default:  state_d = ST_IDLE;
            endcase

            rel_ok   = release_valid && busy_q[release_slot];
            badrel_d = release_valid && !busy_q[release_slot];
            if (rel_ok)
                busy_d[release_slot] = 1'b0;

            if (arb_valid) begin
                busy_d[free_idx] = 1'b1;
                grant_d  = arb_gnt;
                gvalid_d = 1'b1;
                gslot_d  = free_idx;
                ptr_d    = (arb_idx == PTR_LAST) ? '0 : arb_idx + REQ_W'(1);
            end

            if (arb_valid && !rel_ok)
                cnt_d = cnt_q + CNT_W'(1);
            else if (!arb_valid && rel_ok)
                cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign full_d = (cnt_d == CNT_FULL);

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            busy_q   <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            gvalid_q <= 1'b0;
            gslot_q  <= '0;
            full_q   <= 1'b0;
            badrel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            gvalid_q <= gvalid_d;
            gslot_q  <= gslot_d;
            full_q   <= full_d;
            badrel_q <= badrel_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = gvalid_q;
    assign grant_slot  = gslot_q;
    assign slot_busy   = busy_q;
    assign busy_count  = cnt_q;
    assign pool_full   = full_q;
    assign bad_release = badrel_q;

endmodule

// File: tb/tb_bullet_pool_scheduler.sv
// Scoreboard bench for bullet_pool_scheduler (16 slots, 4 requesters).
// Expected grants are queued by the stimulus and popped by a monitor.
module tb_bullet_pool_scheduler;

    logic        clk = 1'b0;
    logic        hard_reset_n;
    logic        game_en;
    logic        game_reset;
    logic        clear_all;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [3:0]  grant_slot;
    logic        release_valid;
    logic [3:0]  release_slot;
    logic [15:0] slot_busy;
    logic [4:0]  busy_count;
    logic        pool_full;
    logic        bad_release;

    typedef struct {
        logic [3:0] g;
        logic [3:0] s;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bullet_pool_scheduler #(
        .NUM_SLOTS  (16),
        .NUM_REQ    (4),
        .SLOT_W     (4),
        .CLEAR_HOLD (4)
    ) dut (
        .clk           (clk),
        .hard_reset_n  (hard_reset_n),
        .game_en       (game_en),
        .game_reset    (game_reset),
        .clear_all     (clear_all),
        .req           (req),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_slot    (grant_slot),
        .release_valid (release_valid),
        .release_slot  (release_slot),
        .slot_busy     (slot_busy),
        .busy_count    (busy_count),
        .pool_full     (pool_full),
        .bad_release   (bad_release)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input int s);
        exp_t e;
        e.g = g;
        e.s = 4'(s);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every presented grant must match the head of the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (hard_reset_n && grant_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_grant: got grant=%b slot=%0d want none",
                             grant, grant_slot);
                end else begin
                    e = exp_q.pop_front();
                    if (grant !== e.g || grant_slot !== e.s) begin
                        bad++;
                        $display("FAIL grant: got grant=%b slot=%0d want grant=%b slot=%0d",
                                 grant, grant_slot, e.g, e.s);
                    end
                end
            end
        end
    end

    initial begin
        hard_reset_n  = 1'b0;
        game_en       = 1'b0;
        game_reset    = 1'b0;
        clear_all     = 1'b0;
        req           = '0;
        release_valid = 1'b0;
        release_slot  = '0;
        step(2);
        chk("rst_busy", 32'(slot_busy), 0);
        chk("rst_count", 32'(busy_count), 0);
        chk("rst_gvalid", 32'(grant_valid), 0);
        chk("rst_full", 32'(pool_full), 0);
        chk("rst_badrel", 32'(bad_release), 0);
        hard_reset_n = 1'b1;

        // single requester takes slots 0,1,2 (first edge is IDLE->RUN)
        game_en = 1'b1;
        req     = 4'b0001;
        for (int i = 0; i < 3; i++) push(4'b0001, i);
        step(4);
        req = '0;
        chk("t1_busy", 32'(slot_busy), 32'h0007);
        chk("t1_count", 32'(busy_count), 3);

        // all requesters, pointer restarted at 0
        game_reset = 1'b1;
        req        = 4'b1111;
        step(1);
        game_reset = 1'b0;
        chk("t2_reset_busy", 32'(slot_busy), 0);
        chk("t2_reset_count", 32'(busy_count), 0);
        push(4'b0001, 0);
        push(4'b0010, 1);
        push(4'b0100, 2);
        push(4'b1000, 3);
        push(4'b0001, 4);
        step(6);
        req = '0;
        chk("t2_busy", 32'(slot_busy), 32'h001F);
        chk("t2_count", 32'(busy_count), 5);

        // fill the pool, hold a request while full, then free slot 5
        req = 4'b0010;
        for (int i = 5; i < 16; i++) push(4'b0010, i);
        step(11);
        chk("t3_full", 32'(pool_full), 1);
        chk("t3_count", 32'(busy_count), 16);
        chk("t3_busy", 32'(slot_busy), 32'hFFFF);
        step(2);
        chk("t3_full_hold", 32'(pool_full), 1);
        release_valid = 1'b1;
        release_slot  = 4'd5;
        push(4'b0010, 5);
        step(1);
        release_valid = 1'b0;
        chk("t3_rel_full", 32'(pool_full), 0);
        chk("t3_rel_count", 32'(busy_count), 15);
        chk("t3_rel_busy", 32'(slot_busy), 32'hFFDF);
        chk("t3_rel_bad", 32'(bad_release), 0);
        step(1);
        req = '0;
        chk("t3_refull", 32'(pool_full), 1);
        chk("t3_refill_busy", 32'(slot_busy), 32'hFFFF);

        // three busy slots, release of a free slot
        game_reset = 1'b1;
        req        = 4'b0001;
        step(1);
        game_reset = 1'b0;
        for (int i = 0; i < 3; i++) push(4'b0001, i);
        step(4);
        req = '0;
        chk("t4_busy", 32'(slot_busy), 32'h0007);
        release_valid = 1'b1;
        release_slot  = 4'd9;
        step(1);
        release_valid = 1'b0;
        chk("t4_bad_pulse", 32'(bad_release), 1);
        chk("t4_bad_busy", 32'(slot_busy), 32'h0007);
        chk("t4_bad_count", 32'(busy_count), 3);
        release_valid = 1'b1;
        release_slot  = 4'd1;
        step(1);
        release_valid = 1'b0;
        chk("t4_bad_drop", 32'(bad_release), 0);
        chk("t4_rel1_busy", 32'(slot_busy), 32'h0005);
        // release slot 0 while allocating: slot 0 is not reused yet
        release_valid = 1'b1;
        release_slot  = 4'd0;
        req           = 4'b0001;
        push(4'b0001, 1);
        step(1);
        release_valid = 1'b0;
        req           = '0;
        chk("t4_both_busy", 32'(slot_busy), 32'h0006);
        chk("t4_both_count", 32'(busy_count), 2);

        // ten busy slots, then a bomb clear with a request held
        game_reset = 1'b1;
        req        = 4'b0001;
        step(1);
        game_reset = 1'b0;
        for (int i = 0; i < 10; i++) push(4'b0001, i);
        step(11);
        req = '0;
        chk("t5_busy", 32'(slot_busy), 32'h03FF);
        chk("t5_count", 32'(busy_count), 10);
        clear_all     = 1'b1;
        req           = 4'b0001;
        release_valid = 1'b1;
        release_slot  = 4'd12;
        step(1);
        clear_all     = 1'b0;
        release_valid = 1'b0;
        chk("t5_clr_busy", 32'(slot_busy), 0);
        chk("t5_clr_count", 32'(busy_count), 0);
        chk("t5_clr_bad", 32'(bad_release), 0);
        chk("t5_clr_gvalid", 32'(grant_valid), 0);
        step(4);
        chk("t5_hold_gvalid", 32'(grant_valid), 0);
        push(4'b0001, 0);
        step(1);
        req = '0;
        chk("t5_grant_seen", 32'(exp_q.size()), 0);

        // game_reset while in CLEAR
        clear_all = 1'b1;
        step(1);
        clear_all = 1'b0;
        step(1);
        game_reset = 1'b1;
        req        = 4'b1111;
        step(1);
        game_reset = 1'b0;
        chk("t6_busy", 32'(slot_busy), 0);
        chk("t6_count", 32'(busy_count), 0);
        chk("t6_gvalid0", 32'(grant_valid), 0);
        push(4'b0001, 0);
        step(1);
        chk("t6_gvalid1", 32'(grant_valid), 0);
        step(1);
        req = '0;
        chk("t6_grant_seen", 32'(exp_q.size()), 0);

        // asynchronous reset while a grant is being presented
        req = 4'b0001;
        push(4'b0001, 1);
        @(posedge clk);
        #3;
        hard_reset_n = 1'b0;
        #1;
        chk("t7_gvalid", 32'(grant_valid), 0);
        chk("t7_grant", 32'(grant), 0);
        chk("t7_busy", 32'(slot_busy), 0);
        chk("t7_count", 32'(busy_count), 0);
        @(negedge clk);
        req = '0;
        step(1);
        hard_reset_n = 1'b1;
        step(2);
        chk("t7_idle_gvalid", 32'(grant_valid), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bullet_pool_scheduler.md
Name: bullet_pool_scheduler

Overview:
- Shares a fixed pool of bullet slots between several spawn requesters: player fire, enemy emitters and boss pattern generators.
- Sits between the spawn sources and the bullet update/render datapath.
- Grants one requester a free slot per cycle using round-robin priority, and tracks which slots are busy.
- Sequenced by the game FSM through game_en, game_reset and the bomb clear pulse.

Parameters:
- NUM_SLOTS, 16: bullet slots in the pool; power of two, 2..64.
- NUM_REQ, 4: number of spawn requesters, 2..8.
- SLOT_W, 4: width of a slot index; equals log2(NUM_SLOTS).
- CLEAR_HOLD, 1000: cycles during which grants stay blocked after a bomb clear; minimum 1.

Ports:
- clk  in  1  system clock
- hard_reset_n  in  1  asynchronous active-low reset
- game_en  in  1  high while gameplay runs; grants happen only while high
- game_reset  in  1  synchronous pulse; frees all slots and restarts arbitration
- clear_all  in  1  bomb pulse; frees all slots, then holds off spawning
- req  in  NUM_REQ  per-requester spawn request; level, held until granted
- grant  out  NUM_REQ  one-hot grant, one-cycle pulse
- grant_valid  out  1  high in the same cycle as any grant bit
- grant_slot  out  SLOT_W  slot index allocated to the granted requester
- release_valid  in  1  datapath reports that a bullet left the screen or hit something
- release_slot  in  SLOT_W  slot being released
- slot_busy  out  NUM_SLOTS  occupancy bitmap, registered
- busy_count  out  SLOT_W+1  number of busy slots
- pool_full  out  1  asserted when busy_count equals NUM_SLOTS
- bad_release  out  1  one-cycle pulse when release_slot was already free

Behaviour:
- Reset state: all outputs 0, state IDLE, round-robin pointer 0, slot_busy all 0.
- States and transitions:
  - IDLE to RUN when game_en is 1.
  - RUN to IDLE when game_en is 0. Occupancy is kept in IDLE; releases are still processed.
  - From any state, clear_all goes to CLEAR and loads the hold counter with CLEAR_HOLD-1.
  - CLEAR counts down. At 0 it goes to RUN if game_en is 1, otherwise to IDLE.
  - game_reset from any state: slot_busy cleared, pointer set to 0, state IDLE, hold counter cleared.
  - game_reset has priority over clear_all.
- Arbitration, RUN only:
  - Search req starting at the pointer and wrapping around; the first set bit wins.
  - The winning slot is the lowest-index free slot.
  - The grant is issued only if at least one slot is free.
  - On a grant, the pointer moves to the winner+1, modulo NUM_REQ. With no grant the pointer holds.
- Latency:
  - grant, grant_valid and grant_slot are registered, so they appear the cycle after req is sampled.
  - The slot_busy bit for the granted slot sets in that same output cycle.
  - A requester may drop req in the cycle it sees its grant. If it keeps req high, it competes again on the next cycle.
- Release:
  - A valid release clears the slot_busy bit on the next edge.
  - A release to a free slot changes nothing and pulses bad_release.
  - A release and an allocation in the same cycle both take effect. The allocation chooses only among slots that were free before the edge, so a slot released this cycle is not reused until the following cycle.
- busy_count:
  - Updated by +1 on a grant, -1 on a valid release, unchanged when both happen.
  - Always equals popcount(slot_busy).
  - Never wraps: a grant requires a free slot, and a release requires a busy slot.
- pool_full, registered from the next-state count:
  - While it is high, requests are held off with no grant and no error.
  - Requests simply wait; no starvation counter is kept.
- clear_all:
  - All slot_busy bits clear on the next edge.
  - Any grant that would otherwise be issued that cycle is suppressed, so grant stays 0.
  - A release in the same cycle is ignored and does not raise bad_release.
- Reset asserted mid-grant: all outputs return to 0 asynchronously, and no partial allocation remains.

Decomposition:
- Shared package stg_pkg holds:
  - state encodings: ST_IDLE, ST_RUN, ST_CLEAR;
  - default constants: NUM_SLOTS, NUM_REQ, CLEAR_HOLD;
  - the slot-index typedef.
- Sub-module rr_arbiter:
  - NUM_REQ-wide, combinational.
  - Inputs: req, pointer, enable. Outputs: one-hot winner and its index.
  - The free-slot priority encoder stays inline in bullet_pool_scheduler.

Test Plan:
- Reset, then game_en=1 and req=4'b0001 held for 3 cycles -> grants on slots 0, 1, 2; busy_count reaches 3; slot_busy=16'h0007.
- req=4'b1111 held with pointer 0 -> grant order 0001, 0010, 0100, 1000, 0001; grant_slot counts 0..4.
- Fill all 16 slots, then req=4'b0010 -> no grant and pool_full=1. Then release_slot=5 -> pool_full drops, and next cycle the grant goes to slot 5.
- Pool holds 3 busy slots, then release_valid with release_slot=9 (free) -> bad_release pulses once; slot_busy and busy_count unchanged.
- Pool holds 10 busy slots, then a clear_all pulse with req=4'b0001 held and CLEAR_HOLD=4 -> slot_busy=0 next cycle; no grant for 4 cycles; first grant on slot 0 in the 6th cycle after the pulse.
- game_reset during CLEAR with game_en=1 -> state IDLE, pointer 0, slot_busy 0; grant on the second cycle after game_reset ends.
